// File: rtl/sbox_array.sv
// sbox_array: AES SubBytes / InvSubBytes engine over a 128-bit state,
// substituting LANES bytes per cycle with a valid/ready handshake on both sides.
`timescale 1ns/1ps

module sbox_array #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] block_in,
  input  logic         inv_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] block_out,
  output logic         busy
);

  localparam int unsigned GROUPS = (LANES == 0) ? 1 : 16 / LANES;
  localparam int unsigned CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

  // Reject lane counts that do not evenly tile the 16-byte state.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sbox_array: LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 forward S-box; entry x sits at bits [2047-8x -: 8].
  localparam logic [2047:0] FWD_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse table is the permutation inverse of the forward table.
  function automatic logic [2047:0] build_inv(input logic [2047:0] fwd);
    logic [2047:0] t;
    logic [7:0]    f;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      f = fwd[{~8'(i), 3'b111} -: 8];
      t[{~f, 3'b111} -: 8] = 8'(i);
    end
    return t;
  endfunction

  localparam logic [2047:0] INV_TAB = build_inv(FWD_TAB);

  // One byte lookup in the table selected by the mode bit.
  function automatic logic [7:0] lookup(input logic [7:0] b, input logic inv);
    logic [7:0] r;
    if (inv) r = INV_TAB[{~b, 3'b111} -: 8];
    else     r = FWD_TAB[{~b, 3'b111} -: 8];
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [127:0]     r_work;
  logic             r_mode;

  logic             w_accept;
  logic [3:0]       w_idx [LANES];
  logic [7:0]       w_sub [LANES];

  // Handshake decode: DONE can hand over to a new block on the same edge.
  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_BUSY);
  assign block_out = r_work;

  // Per-lane lookup on the byte group addressed by the counter.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_idx[l] = 4'(32'(r_cnt) * LANES + 32'(l));
    assign w_sub[l] = lookup(r_work[{~w_idx[l], 3'b111} -: 8], r_mode);
  end

  // Control FSM and datapath: capture, substitute group by group, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_mode  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_work  <= block_in;
            r_mode  <= inv_in;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            r_work[{~w_idx[l], 3'b111} -: 8] <= w_sub[l];
          end
          if (r_cnt == LAST_GRP) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (w_accept) begin
            r_work  <= block_in;
            r_mode  <= inv_in;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end else if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_array.sv
// tb_sbox_array: self-checking bench for sbox_array across all legal lane counts.
`timescale 1ns/1ps

module tb_sbox_array;

  localparam int NI = 5;
  localparam int D4 = 2;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         inv_in = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] block_in = '0;

  logic         ir [NI];
  logic         ov [NI];
  logic         bz [NI];
  logic [127:0] bo [NI];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  always #5 clk = ~clk;

  // Instance g has LANES = 2**g; all share the same stimulus.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    sbox_array #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .block_in  (block_in),
      .inv_in    (inv_in),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .block_out (bo[g]),
      .busy      (bz[g])
    );
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      if (x[7]) x = (x << 1) ^ 8'h1b;
      else      x = x << 1;
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_model();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_fwd[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) m_inv[m_fwd[x]] = 8'(x);
  endtask

  function automatic logic [127:0] model_sub(input logic [127:0] blk, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = blk[127 - 8*k -: 8];
      r[127 - 8*k -: 8] = inv ? m_inv[b] : m_fwd[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic accept(input logic [127:0] b, input logic v);
    in_valid = 1'b1;
    block_in = b;
    inv_in = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int idx, output int lat);
    lat = 0;
    while (ov[idx] !== 1'b1 && lat < 64) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      n_checks++; if (ir[g] !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", g, ir[g]); end
      n_checks++; if (ov[g] !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", g, ov[g]); end
      n_checks++; if (bz[g] !== 1'b0) begin n_errors++; $display("FAIL reset_busy[%0d]: got %b want 0", g, bz[g]); end
      n_checks++; if (bo[g] !== 128'h0) begin n_errors++; $display("FAIL reset_block_out[%0d]: got %h want 0", g, bo[g]); end
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    int lat;
    do_reset();
    accept(PT, 1'b0);
    n_checks++; if (bz[D4] !== 1'b1) begin n_errors++; $display("FAIL fips_busy: got %b want 1", bz[D4]); end
    n_checks++; if (ir[D4] !== 1'b0) begin n_errors++; $display("FAIL fips_in_ready_busy: got %b want 0", ir[D4]); end
    wait_valid(D4, lat);
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL fips_latency: got %0d want 4", lat); end
    n_checks++; if (bo[D4] !== CT) begin n_errors++; $display("FAIL fips_block_out: got %h want %h", bo[D4], CT); end
    n_checks++; if (bo[D4] !== model_sub(PT, 1'b0)) begin n_errors++; $display("FAIL fips_model: got %h want %h", bo[D4], model_sub(PT, 1'b0)); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (ir[D4] !== 1'b1) begin n_errors++; $display("FAIL fips_in_ready_done: got %b want 1", ir[D4]); end
    step();
    out_ready = 1'b0;
    n_checks++; if (ov[D4] !== 1'b0) begin n_errors++; $display("FAIL fips_retired: got %b want 0", ov[D4]); end
    n_checks++; if (bz[D4] !== 1'b0 || ir[D4] !== 1'b1) begin n_errors++; $display("FAIL fips_idle: got busy=%b in_ready=%b want 0 1", bz[D4], ir[D4]); end
  endtask

  task automatic test_inverse_lanes();
    int first [NI];
    do_reset();
    for (int g = 0; g < NI; g++) first[g] = -1;
    accept(CT, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      step();
      for (int g = 0; g < NI; g++)
        if (ov[g] === 1'b1 && first[g] < 0) first[g] = e;
    end
    for (int g = 0; g < NI; g++) begin
      n_checks++; if (first[g] != (16 >> g)) begin n_errors++; $display("FAIL inv_latency[lanes=%0d]: got %0d want %0d", 1 << g, first[g], 16 >> g); end
      n_checks++; if (bo[g] !== PT) begin n_errors++; $display("FAIL inv_block_out[lanes=%0d]: got %h want %h", 1 << g, bo[g], PT); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int lat;
    logic [127:0] blk;
    logic [127:0] exp;
    blk = {4{32'hfcfdfeff}};
    exp = {4{32'hb054bb16}};
    do_reset();
    accept(blk, 1'b0);
    wait_valid(D4, lat);
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL stall_latency: got %0d want 4", lat); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bo[D4] !== exp) begin n_errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, bo[D4], exp); end
      n_checks++; if (ir[D4] !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, ir[D4]); end
      n_checks++; if (ov[D4] !== 1'b1) begin n_errors++; $display("FAIL stall_out_valid[%0d]: got %b want 1", i, ov[D4]); end
      step();
    end
    n_checks++; if (bo[D4] !== exp) begin n_errors++; $display("FAIL stall_final: got %h want %h", bo[D4], exp); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (ov[D4] !== 1'b0) begin n_errors++; $display("FAIL stall_retired: got %b want 0", ov[D4]); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [127:0] a;
    logic [127:0] b;
    logic va;
    logic vb;
    do_reset();
    a = rand128();
    va = 1'($urandom_range(0, 1));
    accept(a, va);
    wait_valid(D4, lat);
    n_checks++; if (bo[D4] !== model_sub(a, va)) begin n_errors++; $display("FAIL b2b_first: got %h want %h", bo[D4], model_sub(a, va)); end
    for (int r = 0; r < 4; r++) begin
      b = rand128();
      vb = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      block_in = b;
      inv_in = vb;
      out_ready = 1'b1;
      #1;
      n_checks++; if (ir[D4] !== 1'b1) begin n_errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", r, ir[D4]); end
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      n_checks++; if (bz[D4] !== 1'b1 || ov[D4] !== 1'b0) begin n_errors++; $display("FAIL b2b_no_bubble[%0d]: got busy=%b out_valid=%b want 1 0", r, bz[D4], ov[D4]); end
      wait_valid(D4, lat);
      n_checks++; if (lat != 4) begin n_errors++; $display("FAIL b2b_latency[%0d]: got %0d want 4", r, lat); end
      n_checks++; if (bo[D4] !== model_sub(b, vb)) begin n_errors++; $display("FAIL b2b_block_out[%0d]: got %h want %h", r, bo[D4], model_sub(b, vb)); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    int seen;
    do_reset();
    accept(rand128(), 1'b0);
    step();
    step();
    n_checks++; if (bz[D4] !== 1'b1) begin n_errors++; $display("FAIL midrst_pre_busy: got %b want 1", bz[D4]); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ov[D4] !== 1'b0) begin n_errors++; $display("FAIL midrst_out_valid: got %b want 0", ov[D4]); end
    n_checks++; if (bz[D4] !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b want 0", bz[D4]); end
    n_checks++; if (ir[D4] !== 1'b1) begin n_errors++; $display("FAIL midrst_in_ready: got %b want 1", ir[D4]); end
    n_checks++; if (bo[D4] !== 128'h0) begin n_errors++; $display("FAIL midrst_block_out: got %h want 0", bo[D4]); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ov[D4] === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL midrst_no_output: got %0d valid cycles want 0", seen); end
    // Reset while a result is waiting in DONE.
    accept(rand128(), 1'b1);
    wait_valid(D4, lat);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    n_checks++; if (ov[D4] !== 1'b0) begin n_errors++; $display("FAIL donerst_out_valid: got %b want 0", ov[D4]); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ov[D4] === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL donerst_no_output: got %0d valid cycles want 0", seen); end
    // Accept on the very first edge after release.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    accept(PT, 1'b0);
    wait_valid(D4, lat);
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL first_edge_latency: got %0d want 4", lat); end
    n_checks++; if (bo[D4] !== CT) begin n_errors++; $display("FAIL first_edge_block_out: got %h want %h", bo[D4], CT); end
  endtask

  task automatic test_ignore_inputs();
    int lat;
    do_reset();
    accept(PT, 1'b0);
    lat = 0;
    while (ov[D4] !== 1'b1 && lat < 64) begin
      in_valid = 1'($urandom_range(0, 1));
      inv_in = ~inv_in;
      block_in = rand128();
      step();
      lat++;
    end
    in_valid = 1'b0;
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL ignore_latency: got %0d want 4", lat); end
    n_checks++; if (bo[D4] !== CT) begin n_errors++; $display("FAIL ignore_block_out: got %h want %h", bo[D4], CT); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    logic [127:0] b;
    logic v;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      b = rand128();
      v = 1'($urandom_range(0, 1));
      accept(b, v);
      wait_valid(0, lat);
      n_checks++; if (lat != 16) begin n_errors++; $display("FAIL rand_latency1[%0d]: got %0d want 16", r, lat); end
      for (int g = 0; g < NI; g++) begin
        n_checks++; if (ov[g] !== 1'b1) begin n_errors++; $display("FAIL rand_out_valid[%0d][lanes=%0d]: got %b want 1", r, 1 << g, ov[g]); end
        n_checks++; if (bo[g] !== model_sub(b, v)) begin n_errors++; $display("FAIL rand_block_out[%0d][lanes=%0d]: got %h want %h", r, 1 << g, bo[g], model_sub(b, v)); end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_fips();
    test_inverse_lanes();
    test_stall();
    test_back_to_back();
    test_reset_mid_busy();
    test_ignore_inputs();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sbox_array.md
SBOX_ARRAY -- requirements
Module: sbox_array

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning bytes substituted per cycle; legal values are 1, 2, 4, 8 and 16, and any other value SHALL fail elaboration.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: block_in and inv_in are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a new block.
REQ-006 The block SHALL have port block_in, input, 128 bits: AES state; byte 0 is bits [127:120], byte 15 is bits [7:0].
REQ-007 The block SHALL have port inv_in, input, 1 bit: 0 selects forward S-box (SubBytes), 1 selects inverse S-box (InvSubBytes).
REQ-008 The block SHALL have port out_valid, output, 1 bit: block_out holds a completed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts block_out.
REQ-010 The block SHALL have port block_out, output, 128 bits: substituted state, same byte order as block_in.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in the BUSY state.

Function
REQ-012 The block SHALL substitute each byte using the FIPS-197 forward table when inv=0 and the FIPS-197 inverse table when inv=1, with LANES independent lookup instances.
REQ-013 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-014 An input SHALL be accepted on a rising edge where in_valid and in_ready are both 1; block_in and inv_in SHALL then be captured into a working register and a mode register.
REQ-015 In IDLE, in_ready SHALL be 1; on accept, the state SHALL go to BUSY and the byte counter SHALL be cleared to 0.
REQ-016 Each BUSY cycle SHALL replace bytes [cnt*LANES .. cnt*LANES+LANES-1] of the working register with their substitutes, then increment cnt by 1.
REQ-017 The final group SHALL be group 16/LANES-1; after its update the state SHALL go to DONE and cnt SHALL wrap to 0.
REQ-018 Latency SHALL be 16/LANES cycles: out_valid rises exactly 16/LANES rising edges after the accept edge (1 edge when LANES=16).
REQ-019 In BUSY, in_ready SHALL be 0; in_valid and changes on block_in/inv_in SHALL be ignored.
REQ-020 In DONE, out_valid SHALL be 1 and block_out SHALL equal the working register, held stable until accepted.
REQ-021 In DONE, an edge with out_ready=1 and in_valid=0 SHALL complete the handshake and return the state to IDLE.
REQ-022 in_ready SHALL equal (state==IDLE) OR (state==DONE AND out_ready); it is combinational from out_ready.
REQ-023 In DONE, an edge with out_ready=1 and in_valid=1 SHALL both retire the current output and accept the new input, going directly to BUSY with no idle bubble.
REQ-024 The mode SHALL be fixed per block; inv_in changes after the accept edge SHALL have no effect on the block in flight.
REQ-025 busy SHALL equal (state==BUSY).
REQ-026 Outside DONE, out_valid SHALL be 0 and block_out SHALL be the current working register contents, which are don't-care to the consumer.

Reset
REQ-027 While rst_n=0, regardless of clk, the block SHALL force state to IDLE, cnt to 0, the working register to 0 and the mode register to 0.
REQ-028 The reset values visible at the outputs SHALL be in_ready=1, out_valid=0, busy=0 and block_out=128'h0.
REQ-029 An assertion of rst_n mid-BUSY or in DONE SHALL discard the in-flight block, with no output produced for it after reset release.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 The bench SHALL drive LANES=4, inv=0, block 00112233445566778899aabbccddeeff, and SHALL require out_valid after exactly 4 cycles with block_out=638293c31bfc33f5c4eeacea4bc12816.
REQ-032 The bench SHALL take the REQ-031 output with inv=1, for LANES in {1, 2, 4, 8, 16}, and SHALL require block_out=00112233445566778899aabbccddeeff after 16, 8, 4, 2 and 1 cycles respectively.
REQ-033 The bench SHALL drive inv=0 on block fcfdfeff repeated 4 times, holding out_ready=0 for 5 cycles, and SHALL require block_out=b054bb16 repeated 4 times, held stable with in_ready=0 throughout the stall.
REQ-034 The bench SHALL test back-to-back operation: with a block pending in DONE, assert out_ready=1 and in_valid=1 on the same edge, and require the next block's out_valid exactly 16/LANES edges later with no IDLE cycle in between.
REQ-035 The bench SHALL pulse rst_n low for 1 ns during BUSY (cnt=2, LANES=4), and SHALL require immediate out_valid=0, busy=0, in_ready=1 and block_out=0, with no out_valid afterwards until a new accept.
REQ-036 The bench SHALL toggle inv_in and block_in every cycle during BUSY, and SHALL require a result identical to REQ-031.
